if_fetch_ctrl: RTL and testbench
================================

Name: if_fetch_ctrl

Overview:
- Sequences the instruction-fetch stage in two phases.
- Boot phase: streams a program image into instruction memory over a valid/ready handshake, driving WE, W_Addr and W_Ins.
- Run phase: drives newPC into the fetch stage each cycle, selecting redirect target, held PC or sequential PC, and flags bubbles to decode.
- Sits between the boot/debug host, the instruction memory write port and the PC register.

Parameters:
- IM_WORDS, 256, instruction memory depth in 32-bit words; power of two, 4..65536.
- AW, 8, word-address width; must equal log2(IM_WORDS).
- RESET_VECTOR, 32'h0000_0000, first PC issued on entry to RUN; word aligned.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  synchronous active-low reset; RST=0 sampled at posedge resets the block.
- LD_START  in  1  one-cycle pulse; begins a program load (honoured only in IDLE or RUN).
- LD_VALID  in  1  load word valid.
- LD_DATA  in  32  load word.
- LD_LAST  in  1  qualifies the final word of the image (sampled with LD_VALID).
- LD_READY  out  1  controller accepts LD_DATA this cycle.
- WE  out  1  instruction memory write enable.
- W_Addr  out  AW  instruction memory word write address.
- W_Ins  out  32  instruction memory write data.
- PC  in  32  current PC from fetch stage.
- nextPC  in  32  PC+4 from fetch stage.
- STALL  in  1  hold PC (downstream hazard).
- BR_TAKEN  in  1  redirect request.
- BR_TARGET  in  32  redirect address.
- newPC  out  32  next PC value to fetch stage.
- IF_VALID  out  1  fetched instruction is valid (0 = bubble).
- LD_ERR  out  1  sticky: image exceeded IM_WORDS.
- BUSY  out  1  1 in LOAD or FLUSH.

Behaviour:
- Reset (RST=0):
  - State=IDLE.
  - Outputs: WE=0, W_Addr=0, W_Ins=0, LD_READY=0, newPC=RESET_VECTOR, IF_VALID=0, LD_ERR=0, BUSY=0.
  - Reset mid-load abandons the load immediately; no further WE pulses.
- States: IDLE, LOAD, FLUSH, RUN.
- IDLE:
  - newPC=RESET_VECTOR, IF_VALID=0.
  - LD_START → LOAD.
- LOAD:
  - Entry clears the word counter and LD_ERR.
  - LD_READY=1.
  - Each cycle with LD_VALID&LD_READY: registered WE=1, W_Addr=counter, W_Ins=LD_DATA, all one cycle later; counter+1.
  - Counter reaching IM_WORDS: further words are accepted but not written (WE=0), and LD_ERR sets.
  - Accepted word with LD_LAST=1 → FLUSH.
  - IF_VALID=0 and newPC=RESET_VECTOR throughout.
- FLUSH:
  - Exactly 1 cycle; lets the final write land.
  - LD_READY=0, WE reflects the last word only.
  - Next state RUN.
- RUN, newPC priority each cycle:
  1. BR_TAKEN: newPC=BR_TARGET, IF_VALID=0 for 1 cycle (squash wrong-path fetch).
  2. STALL: newPC=PC, IF_VALID unchanged.
  3. Otherwise: newPC=nextPC, IF_VALID=1.
- RUN entry:
  - First cycle in RUN: newPC=RESET_VECTOR, IF_VALID=0.
  - Sequential fetch starts the following cycle.
- Simultaneous events:
  - BR_TAKEN with STALL: branch wins.
  - LD_START in RUN: → LOAD next cycle, overriding branch/stall.
  - LD_START in LOAD/FLUSH: ignored.
- Combinational/registered split:
  - newPC is combinational from state and RUN inputs.
  - WE/W_Addr/W_Ins/LD_ERR/IF_VALID are registered.
- Address wrap: the counter does not wrap; it saturates at IM_WORDS with error.
- BUSY is combinational from state.

Optional Feature:
- Macro: IF_LOAD_CHECKSUM_EN.
- When defined:
  - Adds output LD_SUM[31:0], the modulo-2^32 sum of all words written (not dropped) in the current load.
  - LD_SUM clears on LOAD entry and on reset, updates with the registered write, and holds in FLUSH/RUN.
- When undefined: the port is absent and no adder is present.

Test Plan:
1. Reset then LD_START, then 4 words 0x20080001, 0x20090002, 0x01095020, 0x00000000 (last with LD_LAST=1):
   - WE pulses at W_Addr 0..3 with matching data.
   - FLUSH 1 cycle, then RUN with newPC=0, IF_VALID=0, then newPC tracks nextPC (PC=0 → 4 → 8).
2. Load with LD_VALID toggling 1,0,1,0:
   - Only accepted words are written, addresses contiguous 0,1.
   - LD_READY stays 1 in LOAD.
3. IM_WORDS=4, load 6 words:
   - WE only for addresses 0..3.
   - LD_ERR=1 after the 5th word and remains through RUN.
   - A new LD_START clears it.
4. In RUN at PC=0x10, STALL=1 for 3 cycles → newPC=0x10 each cycle; release → newPC=0x14.
5. In RUN, BR_TAKEN=1 with BR_TARGET=0x40 and STALL=1 → newPC=0x40, IF_VALID=0 next cycle, then 1.
6. RST=0 asserted mid-LOAD after 2 words:
   - Next cycle IDLE, WE=0, outputs at reset values.
   - With IF_LOAD_CHECKSUM_EN, words 1,2,3 give LD_SUM=6, and a reset gives LD_SUM=0.

Source files
------------

// File: rtl/if_fetch_ctrl_if.sv
// Load, imem-write and fetch bundle for if_fetch_ctrl; slave = controller side.
// LD_SUM exists only when IF_LOAD_CHECKSUM_EN is defined.
interface if_fetch_ctrl_if #(
    parameter int AW = 8
);
    logic          LD_START;
    logic          LD_VALID;
    logic [31:0]   LD_DATA;
    logic          LD_LAST;
    logic          LD_READY;
    logic          WE;
    logic [AW-1:0] W_Addr;
    logic [31:0]   W_Ins;
    logic [31:0]   PC;
    logic [31:0]   nextPC;
    logic          STALL;
    logic          BR_TAKEN;
    logic [31:0]   BR_TARGET;
    logic [31:0]   newPC;
    logic          IF_VALID;
    logic          LD_ERR;
    logic          BUSY;
`ifdef IF_LOAD_CHECKSUM_EN
    logic [31:0]   LD_SUM;
`endif

    modport master (
        output LD_START, LD_VALID, LD_DATA, LD_LAST, PC, nextPC, STALL, BR_TAKEN, BR_TARGET,
        input  LD_READY, WE, W_Addr, W_Ins, newPC, IF_VALID, LD_ERR, BUSY
`ifdef IF_LOAD_CHECKSUM_EN
        , input LD_SUM
`endif
    );

    modport slave (
        input  LD_START, LD_VALID, LD_DATA, LD_LAST, PC, nextPC, STALL, BR_TAKEN, BR_TARGET,
        output LD_READY, WE, W_Addr, W_Ins, newPC, IF_VALID, LD_ERR, BUSY
`ifdef IF_LOAD_CHECKSUM_EN
        , output LD_SUM
`endif
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Boot-load then run fetch sequencer: imem writes land 1 cycle after acceptance, LD_READY=1 whole LOAD.
// newPC is combinational; optional load checksum (LD_SUM) under IF_LOAD_CHECKSUM_EN.
module if_fetch_ctrl #(
    parameter int          IM_WORDS     = 256,
    parameter int          AW           = 8,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic          CLK,
    input  logic          RST,
    if_fetch_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    localparam logic [AW:0] LP_WORDS = (AW+1)'(IM_WORDS);

    state_t        r_state;
    logic [AW:0]   r_cnt;
    logic          r_we;
    logic [AW-1:0] r_waddr;
    logic [31:0]   r_wins;
    logic          r_ld_err;
    logic          r_if_valid;
    logic          r_run_first;
`ifdef IF_LOAD_CHECKSUM_EN
    logic [31:0]   r_sum;
`endif

    logic          w_accept;
    logic [31:0]   w_new_pc;

    assign w_accept = (r_state == S_LOAD) && bus.LD_VALID;

    always_comb begin
        w_new_pc = RESET_VECTOR;
        if (r_state == S_RUN && !r_run_first) begin
            if (bus.BR_TAKEN)
                w_new_pc = bus.BR_TARGET;
            else if (bus.STALL)
                w_new_pc = bus.PC;
            else
                w_new_pc = bus.nextPC;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wins      <= '0;
            r_ld_err    <= 1'b0;
            r_if_valid  <= 1'b0;
            r_run_first <= 1'b0;
`ifdef IF_LOAD_CHECKSUM_EN
            r_sum       <= '0;
`endif
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_if_valid <= 1'b0;
                    if (bus.LD_START) begin
                        r_state  <= S_LOAD;
                        r_cnt    <= '0;
                        r_ld_err <= 1'b0;
`ifdef IF_LOAD_CHECKSUM_EN
                        r_sum    <= '0;
`endif
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        // Counter saturates at IM_WORDS; overflow words are consumed but dropped.
                        if (r_cnt < LP_WORDS) begin
                            r_we    <= 1'b1;
                            r_waddr <= r_cnt[AW-1:0];
                            r_wins  <= bus.LD_DATA;
                            r_cnt   <= r_cnt + 1'b1;
`ifdef IF_LOAD_CHECKSUM_EN
                            r_sum   <= r_sum + bus.LD_DATA;
`endif
                        end else begin
                            r_ld_err <= 1'b1;
                        end
                        if (bus.LD_LAST)
                            r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    r_state     <= S_RUN;
                    r_run_first <= 1'b1;
                    r_if_valid  <= 1'b0;
                end
                S_RUN: begin
                    r_run_first <= 1'b0;
                    if (bus.LD_START) begin
                        r_state    <= S_LOAD;
                        r_cnt      <= '0;
                        r_ld_err   <= 1'b0;
                        r_if_valid <= 1'b0;
`ifdef IF_LOAD_CHECKSUM_EN
                        r_sum      <= '0;
`endif
                    end else if (r_run_first) begin
                        r_if_valid <= 1'b1;
                    end else if (bus.BR_TAKEN) begin
                        r_if_valid <= 1'b0;
                    end else if (!bus.STALL) begin
                        r_if_valid <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.LD_READY = (r_state == S_LOAD);
    assign bus.BUSY     = (r_state == S_LOAD) || (r_state == S_FLUSH);
    assign bus.WE       = r_we;
    assign bus.W_Addr   = r_waddr;
    assign bus.W_Ins    = r_wins;
    assign bus.newPC    = w_new_pc;
    assign bus.IF_VALID = r_if_valid;
    assign bus.LD_ERR   = r_ld_err;
`ifdef IF_LOAD_CHECKSUM_EN
    assign bus.LD_SUM   = r_sum;
`endif
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench: a 256-word instance for load/run sequencing and a 4-word instance for overflow.
module tb_if_fetch_ctrl;
    logic clk;
    logic rst_a;
    logic rst_b;
    int   total;
    int   bad;

    if_fetch_ctrl_if #(.AW(8)) bus_a ();
    if_fetch_ctrl_if #(.AW(2)) bus_b ();

    if_fetch_ctrl #(.IM_WORDS(256), .AW(8), .RESET_VECTOR(32'h0000_0000)) dut_a (
        .CLK(clk), .RST(rst_a), .bus(bus_a.slave)
    );
    if_fetch_ctrl #(.IM_WORDS(4), .AW(2), .RESET_VECTOR(32'h0000_0100)) dut_b (
        .CLK(clk), .RST(rst_b), .bus(bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] exp_npc;
        logic        exp_ifv;
    } vec_t;

    vec_t vt[14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs_a();
        bus_a.LD_START = 0; bus_a.LD_VALID = 0; bus_a.LD_DATA = 0; bus_a.LD_LAST = 0;
        bus_a.PC = 0; bus_a.nextPC = 0; bus_a.STALL = 0; bus_a.BR_TAKEN = 0; bus_a.BR_TARGET = 0;
    endtask

    initial begin
        logic [31:0] img[4];
        total = 0;
        bad   = 0;
        img[0] = 32'h2008_0001; img[1] = 32'h2009_0002;
        img[2] = 32'h0109_5020; img[3] = 32'h0000_0000;

        vt[0]  = '{0, 0, 32'h0,  32'h08, 32'h0C, 32'h0C, 1};
        vt[1]  = '{0, 0, 32'h0,  32'h0C, 32'h10, 32'h10, 1};
        vt[2]  = '{1, 0, 32'h0,  32'h10, 32'h14, 32'h10, 1};
        vt[3]  = '{1, 0, 32'h0,  32'h10, 32'h14, 32'h10, 1};
        vt[4]  = '{1, 0, 32'h0,  32'h10, 32'h14, 32'h10, 1};
        vt[5]  = '{0, 0, 32'h0,  32'h10, 32'h14, 32'h14, 1};
        vt[6]  = '{1, 1, 32'h40, 32'h14, 32'h18, 32'h40, 1};
        vt[7]  = '{0, 0, 32'h0,  32'h40, 32'h44, 32'h44, 0};
        vt[8]  = '{0, 0, 32'h0,  32'h44, 32'h48, 32'h48, 1};
        vt[9]  = '{0, 1, 32'h80, 32'h48, 32'h4C, 32'h80, 1};
        vt[10] = '{1, 0, 32'h0,  32'h80, 32'h84, 32'h80, 0};
        vt[11] = '{1, 0, 32'h0,  32'h80, 32'h84, 32'h80, 0};
        vt[12] = '{0, 0, 32'h0,  32'h80, 32'h84, 32'h84, 0};
        vt[13] = '{0, 0, 32'h0,  32'h84, 32'h88, 32'h88, 1};

        idle_inputs_a();
        bus_b.LD_START = 0; bus_b.LD_VALID = 0; bus_b.LD_DATA = 0; bus_b.LD_LAST = 0;
        bus_b.PC = 0; bus_b.nextPC = 0; bus_b.STALL = 0; bus_b.BR_TAKEN = 0; bus_b.BR_TARGET = 0;
        rst_a = 0;
        rst_b = 0;
        step();
        step();

        chk("rst_we", bus_a.WE, 0);
        chk("rst_waddr", bus_a.W_Addr, 0);
        chk("rst_wins", bus_a.W_Ins, 0);
        chk("rst_ready", bus_a.LD_READY, 0);
        chk("rst_newpc", bus_a.newPC, 0);
        chk("rst_ifv", bus_a.IF_VALID, 0);
        chk("rst_err", bus_a.LD_ERR, 0);
        chk("rst_busy", bus_a.BUSY, 0);
        rst_a = 1;
        rst_b = 1;
        step();

        // Basic 4-word image then run entry.
        bus_a.LD_START = 1;
        step();
        bus_a.LD_START = 0;
        chk("load_ready", bus_a.LD_READY, 1);
        chk("load_busy", bus_a.BUSY, 1);
        for (int i = 0; i < 4; i++) begin
            bus_a.LD_VALID = 1;
            bus_a.LD_DATA  = img[i];
            bus_a.LD_LAST  = (i == 3);
            step();
            chk("img_we", bus_a.WE, 1);
            chk("img_addr", bus_a.W_Addr, i);
            chk("img_data", bus_a.W_Ins, img[i]);
        end
        bus_a.LD_VALID = 0;
        bus_a.LD_LAST  = 0;
        chk("flush_busy", bus_a.BUSY, 1);
        chk("flush_ready", bus_a.LD_READY, 0);
        step();
        chk("run0_we", bus_a.WE, 0);
        chk("run0_busy", bus_a.BUSY, 0);
        chk("run0_newpc", bus_a.newPC, 0);
        chk("run0_ifv", bus_a.IF_VALID, 0);
        step();
        bus_a.PC = 32'h0; bus_a.nextPC = 32'h4;
        #1 chk("run1_newpc", bus_a.newPC, 32'h4);
        step();
        bus_a.PC = 32'h4; bus_a.nextPC = 32'h8;
        #1 chk("run2_newpc", bus_a.newPC, 32'h8);
        chk("run2_ifv", bus_a.IF_VALID, 1);
        step();

        for (int i = 0; i < 14; i++) begin
            bus_a.STALL = vt[i].stall;
            bus_a.BR_TAKEN = vt[i].br;
            bus_a.BR_TARGET = vt[i].tgt;
            bus_a.PC = vt[i].pc;
            bus_a.nextPC = vt[i].npc;
            #1;
            chk($sformatf("vec%0d_newpc", i), bus_a.newPC, vt[i].exp_npc);
            chk($sformatf("vec%0d_ifv", i), bus_a.IF_VALID, vt[i].exp_ifv);
            step();
        end

        // LD_START in RUN beats a simultaneous branch and stall.
        bus_a.LD_START = 1; bus_a.BR_TAKEN = 1; bus_a.STALL = 1; bus_a.BR_TARGET = 32'hC0;
        step();
        idle_inputs_a();
        #1;
        chk("reload_busy", bus_a.BUSY, 1);
        chk("reload_ready", bus_a.LD_READY, 1);
        chk("reload_ifv", bus_a.IF_VALID, 0);
        chk("reload_newpc", bus_a.newPC, 0);

        // LD_VALID toggling 1,0,1,0.
        bus_a.LD_VALID = 1; bus_a.LD_DATA = 32'hAAAA_0000;
        step();
        chk("tog0_we", bus_a.WE, 1);
        chk("tog0_addr", bus_a.W_Addr, 0);
        chk("tog0_data", bus_a.W_Ins, 32'hAAAA_0000);
        bus_a.LD_VALID = 0;
        step();
        chk("tog1_we", bus_a.WE, 0);
        chk("tog1_ready", bus_a.LD_READY, 1);
        bus_a.LD_VALID = 1; bus_a.LD_DATA = 32'hAAAA_0001; bus_a.LD_LAST = 1;
        step();
        chk("tog2_we", bus_a.WE, 1);
        chk("tog2_addr", bus_a.W_Addr, 1);
        chk("tog2_data", bus_a.W_Ins, 32'hAAAA_0001);
        bus_a.LD_VALID = 0; bus_a.LD_LAST = 0;
        step();
        chk("tog3_we", bus_a.WE, 0);
        chk("tog3_busy", bus_a.BUSY, 0);
        step();

        // Reset mid-load after two words.
        bus_a.LD_START = 1;
        step();
        bus_a.LD_START = 0;
        for (int i = 1; i <= 2; i++) begin
            bus_a.LD_VALID = 1; bus_a.LD_DATA = i;
            step();
        end
`ifdef IF_LOAD_CHECKSUM_EN
        chk("sum_mid", bus_a.LD_SUM, 3);
`endif
        bus_a.LD_DATA = 3;
        rst_a = 0;
        step();
        chk("mrst_we", bus_a.WE, 0);
        chk("mrst_busy", bus_a.BUSY, 0);
        chk("mrst_ready", bus_a.LD_READY, 0);
        chk("mrst_waddr", bus_a.W_Addr, 0);
        chk("mrst_wins", bus_a.W_Ins, 0);
        chk("mrst_newpc", bus_a.newPC, 0);
`ifdef IF_LOAD_CHECKSUM_EN
        chk("mrst_sum", bus_a.LD_SUM, 0);
`endif
        rst_a = 1;
        step();
        chk("idle_we", bus_a.WE, 0);
        chk("idle_ready", bus_a.LD_READY, 0);
        bus_a.LD_VALID = 0;

        // Words 1,2,3 then reset.
        bus_a.LD_START = 1;
        step();
        bus_a.LD_START = 0;
        for (int i = 1; i <= 3; i++) begin
            bus_a.LD_VALID = 1; bus_a.LD_DATA = i; bus_a.LD_LAST = (i == 3);
            step();
        end
        bus_a.LD_VALID = 0; bus_a.LD_LAST = 0;
        chk("sum3_addr", bus_a.W_Addr, 2);
        step();
`ifdef IF_LOAD_CHECKSUM_EN
        chk("sum3_run", bus_a.LD_SUM, 6);
`endif
        rst_a = 0;
        step();
`ifdef IF_LOAD_CHECKSUM_EN
        chk("sum3_rst", bus_a.LD_SUM, 0);
`endif
        chk("sum3_rst_busy", bus_a.BUSY, 0);
        rst_a = 1;

        // Overflow on a 4-word memory.
        bus_b.LD_START = 1;
        step();
        bus_b.LD_START = 0;
        chk("b_load_newpc", bus_b.newPC, 32'h100);
        for (int i = 0; i < 6; i++) begin
            bus_b.LD_VALID = 1; bus_b.LD_DATA = 32'hB0 + i; bus_b.LD_LAST = (i == 5);
            step();
            chk($sformatf("b%0d_we", i), bus_b.WE, (i < 4) ? 1 : 0);
            if (i < 4) begin
                chk($sformatf("b%0d_addr", i), bus_b.W_Addr, i);
                chk($sformatf("b%0d_data", i), bus_b.W_Ins, 32'hB0 + i);
            end
            chk($sformatf("b%0d_err", i), bus_b.LD_ERR, (i >= 4) ? 1 : 0);
        end
        bus_b.LD_VALID = 0; bus_b.LD_LAST = 0;
        step();
        chk("b_run_err", bus_b.LD_ERR, 1);
        chk("b_run_we", bus_b.WE, 0);
        chk("b_run_newpc", bus_b.newPC, 32'h100);
`ifdef IF_LOAD_CHECKSUM_EN
        chk("b_sum", bus_b.LD_SUM, 32'h2C6);
`endif
        step();
        chk("b_run_err2", bus_b.LD_ERR, 1);
        bus_b.LD_START = 1;
        step();
        bus_b.LD_START = 0;
        chk("b_clr_err", bus_b.LD_ERR, 0);
        chk("b_clr_ready", bus_b.LD_READY, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
